// File: rtl/window_gen_3_3.sv
`default_nettype none
// window_gen_3_3: raster-order pixel stream to 3x3 sliding windows (valid region only),
// two line buffers plus a 3x3 register window, ready/valid on both sides.
module window_gen_3_3 #(
  parameter int IMG_W = 8,
  parameter int IMG_H = 8,
  parameter int PIX_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [PIX_W-1:0]     pix_in,
  input  logic                 pix_valid,
  output logic                 pix_ready,
  output logic [9*PIX_W-1:0]   patch,
  output logic                 patch_valid,
  input  logic                 patch_ready,
  output logic                 patch_last
);

  localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

  logic [CW-1:0]    col;
  logic [RW-1:0]    row;
  logic [PIX_W-1:0] lb_top [IMG_W];
  logic [PIX_W-1:0] lb_mid [IMG_W];
  // Two older columns of the window per row; the newest column comes straight from the inputs.
  logic [PIX_W-1:0] win_r  [3][2];

  logic             accept;
  logic             produce;
  logic [PIX_W-1:0] top_new;
  logic [PIX_W-1:0] mid_new;

  assign pix_ready = !patch_valid || patch_ready;
  assign accept    = pix_valid && pix_ready;
  assign produce   = accept && (col >= CW'(2)) && (row >= RW'(2));
  assign top_new   = lb_top[col];
  assign mid_new   = lb_mid[col];

  always_ff @(posedge clk) begin
    if (accept) begin
      lb_top[col] <= mid_new;
      lb_mid[col] <= pix_in;
      win_r[0][0] <= win_r[0][1];
      win_r[0][1] <= top_new;
      win_r[1][0] <= win_r[1][1];
      win_r[1][1] <= mid_new;
      win_r[2][0] <= win_r[2][1];
      win_r[2][1] <= pix_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      col         <= '0;
      row         <= '0;
      patch       <= '0;
      patch_valid <= 1'b0;
      patch_last  <= 1'b0;
    end else begin
      if (accept) begin
        if (col == COL_LAST) begin
          col <= '0;
          row <= (row == ROW_LAST) ? '0 : row + RW'(1);
        end else begin
          col <= col + CW'(1);
        end
      end
      if (produce) begin
        patch       <= {win_r[0][0], win_r[0][1], top_new,
                        win_r[1][0], win_r[1][1], mid_new,
                        win_r[2][0], win_r[2][1], pix_in};
        patch_valid <= 1'b1;
        patch_last  <= (col == COL_LAST) && (row == ROW_LAST);
      end else if (patch_ready) begin
        patch_valid <= 1'b0;
        patch_last  <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_window_gen_3_3.sv
`default_nettype none
// tb_window_gen_3_3: scoreboard bench driving a 4x4 and an 8x8 instance from shared inputs.
module tb_window_gen_3_3;
  localparam int PW = 16;

  typedef struct {
    logic [9*PW-1:0] patch;
    logic            last;
    int              cyc;
  } entry_t;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [PW-1:0]   pix_in = '0;
  logic            pix_valid = 1'b0;
  logic            patch_ready = 1'b1;
  logic            sel = 1'b0;

  logic            rdy4, pv4, pl4, rdy8, pv8, pl8;
  logic [9*PW-1:0] patch4, patch8;
  logic            s_ready, s_valid, s_last;
  logic [9*PW-1:0] s_patch;

  entry_t sb[$];
  entry_t mon_e;
  int cyc = 0;
  int passed = 0;
  int total = 0;
  int n_seen = 0;
  int n_last = 0;
  logic chk_lat = 1'b0;

  window_gen_3_3 #(.IMG_W(4), .IMG_H(4), .PIX_W(PW)) u4 (
    .clk(clk), .rst(rst), .pix_in(pix_in), .pix_valid(pix_valid), .pix_ready(rdy4),
    .patch(patch4), .patch_valid(pv4), .patch_ready(patch_ready), .patch_last(pl4));

  window_gen_3_3 #(.IMG_W(8), .IMG_H(8), .PIX_W(PW)) u8 (
    .clk(clk), .rst(rst), .pix_in(pix_in), .pix_valid(pix_valid), .pix_ready(rdy8),
    .patch(patch8), .patch_valid(pv8), .patch_ready(patch_ready), .patch_last(pl8));

  assign s_ready = sel ? rdy8   : rdy4;
  assign s_valid = sel ? pv8    : pv4;
  assign s_last  = sel ? pl8    : pl4;
  assign s_patch = sel ? patch8 : patch4;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [9*PW-1:0] exp_win(input int base, input int w, input int r, input int c);
    logic [9*PW-1:0] p;
    p = '0;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        p[(8 - (i*3 + j))*PW +: PW] = PW'(base + (r - 2 + i)*w + (c - 2 + j));
    return p;
  endfunction

  // Consumption monitor: every consumed patch is popped from the scoreboard.
  always @(negedge clk) begin
    if (s_valid && patch_ready && !rst) begin
      n_seen++;
      if (s_last) n_last++;
      total++;
      if (sb.size() == 0) begin
        $display("FAIL unexpected_patch: got patch %h last=%b, required no patch", s_patch, s_last);
      end else begin
        mon_e = sb.pop_front();
        if (s_patch !== mon_e.patch || s_last !== mon_e.last)
          $display("FAIL patch_content: got %h last=%b, required %h last=%b",
                   s_patch, s_last, mon_e.patch, mon_e.last);
        else passed++;
        if (chk_lat) begin
          total++;
          if (cyc - mon_e.cyc !== 1)
            $display("FAIL patch_latency: got %0d cycles, required 1", cyc - mon_e.cyc);
          else passed++;
        end
      end
    end
  end

  task automatic apply_reset();
    pix_valid = 1'b0;
    patch_ready = 1'b1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    sb.delete();
    n_seen = 0;
    n_last = 0;
  endtask

  task automatic send_pix(input logic [PW-1:0] v, input logic push, input entry_t e);
    int t;
    entry_t q;
    t = 0;
    q = e;
    pix_valid = 1'b1;
    pix_in = v;
    @(negedge clk);
    while (!s_ready) begin
      t++;
      if (t > 50) begin
        total++;
        $display("FAIL pix_ready_timeout: got pix_ready=0 for %0d cycles, required 1", t);
        pix_valid = 1'b0;
        return;
      end
      @(negedge clk);
    end
    if (push) begin
      q.cyc = cyc;
      sb.push_back(q);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input int base, input int w, input int h, input logic gaps);
    entry_t e;
    for (int r = 0; r < h; r++) begin
      for (int c = 0; c < w; c++) begin
        if (gaps) begin
          while ($urandom_range(1) == 1) begin
            pix_valid = 1'b0;
            pix_in = PW'($urandom);
            @(posedge clk);
            #1;
          end
        end
        e.patch = exp_win(base, w, r, c);
        e.last  = (r == h - 1) && (c == w - 1);
        e.cyc   = 0;
        send_pix(PW'(base + r*w + c), (r >= 2) && (c >= 2), e);
      end
    end
    pix_valid = 1'b0;
  endtask

  task automatic finish_frame(input string name, input int n_exp, input int last_exp);
    repeat (6) @(posedge clk);
    #1;
    total++;
    if (n_seen !== n_exp) $display("FAIL %s_count: got %0d patches, required %0d", name, n_seen, n_exp);
    else passed++;
    total++;
    if (n_last !== last_exp) $display("FAIL %s_last_count: got %0d, required %0d", name, n_last, last_exp);
    else passed++;
    total++;
    if (sb.size() !== 0) $display("FAIL %s_pending: got %0d undelivered, required 0", name, sb.size());
    else passed++;
  endtask

  task automatic test_reset();
    sel = 1'b0;
    rst = 1'b1;
    pix_valid = 1'b0;
    patch_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    total++;
    if (pv4 !== 1'b0 || pv8 !== 1'b0) $display("FAIL reset_valid: got %b/%b, required 0/0", pv4, pv8);
    else passed++;
    total++;
    if (pl4 !== 1'b0 || pl8 !== 1'b0) $display("FAIL reset_last: got %b/%b, required 0/0", pl4, pl8);
    else passed++;
    total++;
    if (patch4 !== '0 || patch8 !== '0) $display("FAIL reset_patch: got %h, required 0", patch4);
    else passed++;
    @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    total++;
    if (rdy4 !== 1'b1 || rdy8 !== 1'b1) $display("FAIL reset_ready: got %b/%b, required 1/1", rdy4, rdy8);
    else passed++;
  endtask

  task automatic test_basic();
    sel = 1'b0;
    apply_reset();
    chk_lat = 1'b1;
    send_frame(1, 4, 4, 1'b0);
    finish_frame("basic", 4, 1);
  endtask

  task automatic test_stall();
    logic [9*PW-1:0] first;
    sel = 1'b0;
    apply_reset();
    chk_lat = 1'b0;
    first = exp_win(1, 4, 2, 2);
    fork
      send_frame(1, 4, 4, 1'b0);
      begin
        int t;
        t = 0;
        @(posedge clk);
        #1;
        while (!s_valid && t < 200) begin
          t++;
          @(posedge clk);
          #1;
        end
        if (!s_valid) begin
          total++;
          $display("FAIL stall_first_patch: got no patch in %0d cycles, required one", t);
        end else begin
          patch_ready = 1'b0;
          for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            total++;
            if (s_valid !== 1'b1 || s_patch !== first)
              $display("FAIL stall_hold: got valid=%b %h, required valid=1 %h", s_valid, s_patch, first);
            else passed++;
            total++;
            if (s_ready !== 1'b0) $display("FAIL stall_pix_ready: got %b, required 0", s_ready);
            else passed++;
            @(posedge clk);
            #1;
          end
          patch_ready = 1'b1;
        end
      end
    join
    finish_frame("stall", 4, 1);
  endtask

  task automatic test_gaps();
    sel = 1'b1;
    apply_reset();
    chk_lat = 1'b0;
    send_frame(1, 8, 8, 1'b1);
    finish_frame("gaps", 36, 1);
  endtask

  task automatic test_back_to_back();
    sel = 1'b0;
    apply_reset();
    chk_lat = 1'b1;
    send_frame(1, 4, 4, 1'b0);
    send_frame(101, 4, 4, 1'b0);
    finish_frame("b2b", 8, 2);
  endtask

  task automatic test_reset_midframe();
    entry_t e;
    sel = 1'b0;
    apply_reset();
    e.patch = '0;
    e.last = 1'b0;
    e.cyc = 0;
    for (int i = 0; i < 6; i++) send_pix(PW'(i + 1), 1'b0, e);
    pix_valid = 1'b0;
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      total++;
      if (s_valid !== 1'b0) $display("FAIL midrst_valid: got %b, required 0", s_valid);
      else passed++;
      @(posedge clk);
      #1;
    end
    rst = 1'b0;
    chk_lat = 1'b1;
    send_frame(1, 4, 4, 1'b0);
    finish_frame("midrst", 4, 1);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_gaps();
    test_back_to_back();
    test_reset_midframe();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got simulation still running, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire

// File: doc/window_gen_3_3.md
WINDOW_GEN_3_3 -- requirements
Module: window_gen_3_3

Interface
REQ-001 Parameter IMG_W, default 8, meaning pixels per image row (range 3..1024).
REQ-002 Parameter IMG_H, default 8, meaning rows per frame (range 3..1024).
REQ-003 Parameter PIX_W, default 16, meaning pixel width in bits.
REQ-004 CLK  input  1  meaning single clock; all state updates on its rising edge.
REQ-005 RST  input  1  meaning reset, synchronous, active-high.
REQ-006 PIX_IN  input  PIX_W  meaning raster-order pixel, left to right, top to bottom.
REQ-007 PIX_VALID  input  1  meaning PIX_IN holds a pixel.
REQ-008 PIX_READY  output  1  meaning block accepts PIX_IN this cycle.
REQ-009 PATCH  output  9*PIX_W  meaning 3x3 window, row-major: P0 = top-left in PATCH[143:128], P8 = bottom-right in PATCH[15:0].
REQ-010 PATCH_VALID  output  1  meaning PATCH holds a complete window.
REQ-011 PATCH_READY  input  1  meaning downstream conv_3_3 stage consumes PATCH this cycle.
REQ-012 PATCH_LAST  output  1  meaning current PATCH is the final window of the frame.

Function
REQ-013 A pixel SHALL be accepted iff PIX_VALID && PIX_READY; a patch SHALL be consumed iff PATCH_VALID && PATCH_READY.
REQ-014 PIX_READY SHALL equal !PATCH_VALID || PATCH_READY (combinational; one-entry output skid-free stall).
REQ-015 The block SHALL hold two line buffers of IMG_W pixels (rows r-2, r-1) and a 3x3 register window; on each accepted pixel, the window SHALL shift left one column, loading the new column {line r-2[col], line r-1[col], PIX_IN}, and the line buffers SHALL update at [col].
REQ-016 Column counter COL (0..IMG_W-1) and row counter ROW (0..IMG_H-1) SHALL advance on each accepted pixel; COL wraps to 0 and increments ROW at IMG_W-1; ROW wraps to 0 after the last pixel of the frame.
REQ-017 A window SHALL be produced only for accepted pixels with COL>=2 and ROW>=2 (valid convolution, no padding); frame yields (IMG_W-2)*(IMG_H-2) patches.
REQ-018 Latency: PATCH/PATCH_VALID SHALL assert the cycle after the completing pixel is accepted.
REQ-019 PATCH, PATCH_VALID, PATCH_LAST SHALL hold stable while PATCH_VALID && !PATCH_READY.
REQ-020 On consumption with no new window produced the same cycle, PATCH_VALID SHALL deassert; consumption and production in the same cycle SHALL present the new patch with PATCH_VALID held high (full throughput, one patch per cycle).
REQ-021 PATCH_LAST SHALL be 1 only with the patch whose completing pixel is at COL=IMG_W-1, ROW=IMG_H-1.
REQ-022 After the frame-final pixel, the next accepted pixel SHALL be treated as COL=0, ROW=0 of a new frame; stale line-buffer contents SHALL never appear in a PATCH_VALID patch.
REQ-023 Gaps (PIX_VALID low) SHALL not alter any state.
REQ-024 Window pixels SHALL be passed unmodified (no arithmetic, no width change).

Reset
REQ-025 While RST=1 at a clock edge: COL=0, ROW=0, PATCH_VALID=0, PATCH_LAST=0, PATCH=0; line buffers need not be cleared.
REQ-026 PIX_READY SHALL be 1 in the cycle after reset release.
REQ-027 Reset mid-frame SHALL discard the partial frame; next accepted pixel is COL=0, ROW=0.

Verification
REQ-028 IMG_W=IMG_H=4, pixels 1..16 every cycle, PATCH_READY=1 -> 4 patches: {1,2,3,5,6,7,9,10,11}, {2,3,4,6,7,8,10,11,12}, {5,6,7,9,10,11,13,14,15}, {6,7,8,10,11,12,14,15,16}; PATCH_LAST only on the 4th; each 1 cycle after pixels 11,12,15,16 accepted.
REQ-029 Same stream, PATCH_READY=0 for 5 cycles after first patch -> PATCH holds {1..11 window} stable, PIX_READY=0, no pixel lost; resumes with correct sequence.
REQ-030 Random PIX_VALID gaps (50%) on 8x8 ramp -> 36 patches, identical to gap-free run, one PATCH_LAST.
REQ-031 Two back-to-back 4x4 frames (1..16 then 101..116) -> second frame's first patch {101,102,103,105,106,107,109,110,111}; no patch mixes frames.
REQ-032 RST pulsed after 6 pixels of a 4x4 frame, then full frame 1..16 -> outputs exactly as REQ-028; PATCH_VALID=0 during and after RST until pixel 11 accepted.
